node_sampler: RTL and testbench

NODE_SAMPLER -- requirements
Module: node_sampler

---
 rtl/node_sampler.sv | 155 +++++++++++++++
 tb/tb_node_sampler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/node_sampler.sv
// Stochastic binary node sampler: PLAN sigmoid of each signed product, compared against a Galois LFSR.
// Define NODE_SAMPLER_DETERMINISTIC_EN to replace LFSR sampling with a fixed threshold (x > 0).
module node_sampler #(
  parameter int          PRECISION_BITS = 32,
  parameter int          OVERFLOW_BITS  = 8,
  parameter int          NUM_NODES      = 4,
  parameter int          FRAC_BITS      = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          RBM_CLOCK_FREQ = 50_000_000,
  localparam int         PAD_BITS       = PRECISION_BITS + OVERFLOW_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 product_valid,
  input  logic [PAD_BITS-1:0]  product,
  output logic                 product_ready,
  output logic [NUM_NODES-1:0] nodes,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int AW    = PAD_BITS - 1;

  localparam logic [AW-1:0] A_ONE    = AW'(1) << FRAC_BITS;
  localparam logic [AW-1:0] A_2P375  = AW'(19) << (FRAC_BITS - 3);
  localparam logic [AW-1:0] A_FIVE   = AW'(5) << FRAC_BITS;
  localparam logic [16:0]   P_ONE    = 17'h10000;

  if (FRAC_BITS < 16 || FRAC_BITS > PAD_BITS - 4 || RBM_CLOCK_FREQ <= 0) begin : g_bad_params
    $error("node_sampler: illegal FRAC_BITS or RBM_CLOCK_FREQ");
  end

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {SEG_LOW, SEG_MID, SEG_HIGH, SEG_SAT} seg_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic             accept;

  // Stage 1: magnitude and PLAN segment
  logic             in_neg;
  logic [AW-1:0]    in_mag;
  seg_t             in_seg;
  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_neg;
  logic [AW-1:0]    s1_mag;
  seg_t             s1_seg;

  // Stage 2: probability
  logic [16:0]      p_mag;
  logic [16:0]      p_comb;
  logic             s2_valid;
  logic [IDX_W-1:0] s2_idx;
  logic [16:0]      s2_p;

  logic             node_bit;

`ifdef NODE_SAMPLER_DETERMINISTIC_EN
  logic             s1_pos;
  logic             s2_pos;
`else
  logic [15:0]      lfsr;
`endif

  assign accept        = product_valid && (state == CAPTURE);
  assign product_ready = (state == CAPTURE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CAPTURE;
      CAPTURE: if (accept && idx == IDX_W'(NUM_NODES - 1)) next_state = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The most negative input has no positive counterpart, so its magnitude saturates.
  always_comb begin
    in_neg = product[PAD_BITS-1];
    in_mag = product[AW-1:0];
    if (in_neg) begin
      if (product == {1'b1, {AW{1'b0}}}) in_mag = '1;
      else                              in_mag = (~product[AW-1:0]) + AW'(1);
    end
    if (in_mag >= A_FIVE)       in_seg = SEG_SAT;
    else if (in_mag >= A_2P375) in_seg = SEG_HIGH;
    else if (in_mag >= A_ONE)   in_seg = SEG_MID;
    else                        in_seg = SEG_LOW;
  end

  // Shifting the non-negative magnitude truncates the slope term to 16 fractional bits.
  always_comb begin
    p_mag = '0;
    case (s1_seg)
      SEG_SAT:  p_mag = P_ONE;
      SEG_HIGH: p_mag = 17'(s1_mag >> (FRAC_BITS - 11)) + 17'h0D800;
      SEG_MID:  p_mag = 17'(s1_mag >> (FRAC_BITS - 13)) + 17'h0A000;
      default:  p_mag = 17'(s1_mag >> (FRAC_BITS - 14)) + 17'h08000;
    endcase
    p_comb = s1_neg ? (P_ONE - p_mag) : p_mag;
  end

`ifdef NODE_SAMPLER_DETERMINISTIC_EN
  // Tiny positive inputs truncate to exactly 0.5, so the sign flag breaks the tie.
  assign node_bit = (s2_p > 17'h08000) || ((s2_p == 17'h08000) && s2_pos);
`else
  assign node_bit = ({1'b0, lfsr} < s2_p);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      nodes    <= '0;
`ifndef NODE_SAMPLER_DETERMINISTIC_EN
      lfsr     <= LFSR_SEED;
`endif
    end else begin
      state    <= next_state;
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (state == IDLE && start) idx <= '0;
      else if (accept)            idx <= idx + IDX_W'(1);
      if (s2_valid) begin
        nodes[s2_idx] <= node_bit;
`ifndef NODE_SAMPLER_DETERMINISTIC_EN
        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    s1_idx <= idx;
    s1_neg <= in_neg;
    s1_mag <= in_mag;
    s1_seg <= in_seg;
    s2_idx <= s1_idx;
    s2_p   <= p_comb;
`ifdef NODE_SAMPLER_DETERMINISTIC_EN
    s1_pos <= !in_neg && (product != '0);
    s2_pos <= s1_pos;
`endif
  end

endmodule

// File: tb/tb_node_sampler.sv
// Scoreboard bench for node_sampler: a reference sigmoid/LFSR model queues expected bits, p values and done vectors.
module tb_node_sampler;

  localparam int PAD = 40;
  localparam int N   = 4;

  typedef logic [PAD-1:0] vec_t [N];
  typedef struct { int idx; logic b; int due; } node_exp_t;
  typedef struct { logic [N-1:0] vec; int due; } done_exp_t;

  logic           clk = 1'b0;
  logic           rst, start, product_valid;
  logic [PAD-1:0] product;
  logic           product_ready, busy, done;
  logic [N-1:0]   nodes;

  node_sampler #(.NUM_NODES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .product_valid(product_valid), .product(product),
    .product_ready(product_ready), .nodes(nodes), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, accepts = 0, done_count = 0, ones = 0;
  bit stat_en = 1'b0;

  logic [15:0]  m_lfsr = 16'hACE1;
  logic [N-1:0] m_nodes = '0;
  int           acc_idx = 0;
  node_exp_t    nq[$];
  logic [16:0]  pq[$];
  done_exp_t    dq[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [16:0] model_p(input longint x);
    longint a, pa;
    a = (x < 0) ? -x : x;
    if (a > 64'sd549755813887) a = 64'sd549755813887;
    if (a >= 5 * 65536)   pa = 65536;
    else if (a >= 155648) pa = a / 32 + 55296;
    else if (a >= 65536)  pa = a / 8 + 40960;
    else                  pa = a / 4 + 32768;
    if (x < 0) pa = 65536 - pa;
    return pa[16:0];
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    node_exp_t e;
    done_exp_t d;
    longint    x;
    logic [16:0] p;
    logic      b;
    while (nq.size() > 0 && nq[0].due == cyc) begin
      e = nq.pop_front();
      check_eq("node_bit", 64'(nodes[e.idx]), 64'(e.b));
      if (stat_en) ones += int'(nodes[e.idx]);
    end
    if (dut.s2_valid === 1'b1) begin
      if (pq.size() == 0) check_eq("p_spurious", 1, 0);
      else                check_eq("p_value", 64'(dut.s2_p), 64'(pq.pop_front()));
    end
    if (done === 1'b1) begin
      done_count++;
      if (dq.size() == 0) check_eq("done_spurious", 1, 0);
      else begin
        d = dq.pop_front();
        check_eq("done_cycle", 64'(cyc), 64'(d.due));
        check_eq("done_nodes", 64'(nodes), 64'(d.vec));
      end
    end else if (dq.size() > 0 && dq[0].due < cyc) begin
      check_eq("done_timeout", 64'(cyc), 64'(dq[0].due));
      void'(dq.pop_front());
    end
    if (rst) begin
      nq.delete(); pq.delete(); dq.delete();
      m_lfsr = 16'hACE1; m_nodes = '0; acc_idx = 0;
    end else if (product_valid && product_ready) begin
      x = longint'(signed'(product));
      p = model_p(x);
`ifdef NODE_SAMPLER_DETERMINISTIC_EN
      b = (x > 0);
`else
      b = ({1'b0, m_lfsr} < p);
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
      nq.push_back('{idx: acc_idx, b: b, due: cyc + 3});
      pq.push_back(p);
      m_nodes[acc_idx] = b;
      accepts++;
      if (acc_idx == N - 1) begin
        dq.push_back('{vec: m_nodes, due: cyc + 4});
        acc_idx = 0;
      end else acc_idx++;
    end
  end

  task automatic sweep(input vec_t pv, input bit toggle, input bit poke);
    int tries;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq("busy_on", 64'(busy), 1);
    for (int i = 0; i < N; i++) begin
      product = pv[i];
      product_valid = 1'b1;
      tries = 0;
      while (!product_ready && tries < 20) begin @(posedge clk); #1; tries++; end
      if (tries >= 20) check_eq("ready_timeout", 64'(tries), 0);
      @(posedge clk); #1;
      product_valid = 1'b0;
      if (toggle && i < N - 1) begin
        start = poke;
        product = '1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    tries = 0;
    while (busy && tries < 30) begin @(posedge clk); #1; tries++; end
    if (tries >= 30) check_eq("busy_timeout", 64'(tries), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int a0, d0;
    rst = 1'b1; start = 1'b0; product_valid = 1'b0; product = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_nodes", 64'(nodes), 0);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_done", 64'(done), 0);
    check_eq("rst_ready", 64'(product_ready), 0);
    rst = 1'b0;

    // +/-1.0 for the p checks, then inputs that saturate to p = 1.0
    v[0] = 40'h10000; v[1] = -40'h10000; v[2] = 40'h50000; v[3] = 40'h7FFFFF;
    sweep(v, 1'b0, 1'b0);
    check_eq("sat_pos_nodes", 64'(nodes[3:2]), 64'(2'b11));

    // p = 0 inputs, valid toggling, start poked while busy
    v[0] = -40'h50000; v[1] = 40'h80_0000_0000; v[2] = 40'h0; v[3] = 40'h8000;
    a0 = accepts; d0 = done_count;
    sweep(v, 1'b1, 1'b1);
    check_eq("toggle_accepts", 64'(accepts - a0), 4);
    check_eq("toggle_done_pulses", 64'(done_count - d0), 1);
    check_eq("sat_neg_nodes", 64'(nodes[1:0]), 0);
    repeat (3) @(posedge clk);
    #1 check_eq("start_ignored_busy", 64'(busy), 0);

    v[0] = 40'h0; v[1] = 40'h1; v[2] = -40'h1; v[3] = 40'h8000;
    sweep(v, 1'b0, 1'b0);
`ifdef NODE_SAMPLER_DETERMINISTIC_EN
    check_eq("det_nodes", 64'(nodes), 64'(4'b1010));
`endif

    // Abort after two accepts
    d0 = done_count;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    product = 40'h30000; product_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    product_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_eq("abort_nodes", 64'(nodes), 0);
    check_eq("abort_busy", 64'(busy), 0);
    check_eq("abort_ready", 64'(product_ready), 0);
    repeat (6) @(posedge clk);
    #1 check_eq("abort_no_done", 64'(done_count - d0), 0);
    v[0] = 40'h10000; v[1] = -40'h20000; v[2] = 40'h4000; v[3] = -40'h3000;
    sweep(v, 1'b0, 1'b0);

    // Statistics of p = 0.5 over 4096 samples
    v[0] = '0; v[1] = '0; v[2] = '0; v[3] = '0;
    ones = 0;
    stat_en = 1'b1;
    repeat (1024) sweep(v, 1'b0, 1'b0);
    stat_en = 1'b0;
`ifdef NODE_SAMPLER_DETERMINISTIC_EN
    check_eq("zero_ones", 64'(ones), 0);
`else
    check_eq("ones_in_range", 64'((ones >= 1843) && (ones <= 2253)), 1);
`endif

    check_eq("scoreboard_empty", 64'(nq.size() + dq.size() + pq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
